hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; it consumes the per-instruction need/Tuse/Tnew timing produced by the D-stage timing decoder.
- Tracks destination register and remaining Tnew for every instruction in the E/M/W stages.
- Compares them against the D-stage instruction each cycle and produces the stall, E-bubble and D-stage forwarding selects.
- Also models the mult/div unit busy window, so HI/LO accesses stall while the unit is busy.

Parameters:
- MULT_CYC, 5, busy cycles loaded when mult/multu/madd enters E
- DIV_CYC, 10, busy cycles loaded when div/divu enters E

Ports:
- clk  in  1  core clock; rising edge
- reset_n  in  1  asynchronous, active-low reset
- need_rs_D  in  1  D instruction reads rs
- need_rt_D  in  1  D instruction reads rt
- Tuse_rs_D  in  3  cycles (from D) until rs is consumed
- Tuse_rt_D  in  3  cycles (from D) until rt is consumed
- Tnew_D  in  3  cycles after entering E until the result is ready
- rs_D  in  5  D rs index
- rt_D  in  5  D rt index
- A3_D  in  5  D destination register; 0 = no write
- md_kind_D  in  2  00 none, 01 mult-class, 10 div-class, 11 reserved (treated as 00)
- md_use_D  in  1  D instruction accesses HI/LO or the md unit (mfhi, mflo, mthi, mtlo, mult*, div*, madd)
- stall  out  1  hold PC and the IF/D register
- bubble_E  out  1  equals stall; the D→E register loads a NOP
- fwd_rs_D  out  2  rs source: 0 RF, 1 E, 2 M, 3 W
- fwd_rt_D  out  2  rt source, same encoding
- md_busy  out  1  md counter nonzero

Behaviour:

State, all reset asynchronously on reset_n=0:
- A3_E, tnew_E, A3_M, tnew_M, A3_W: reset to 0.
- md_cnt (4 bits): reset to 0.
- Effect at reset: outputs stall=0, bubble_E=0, fwd=0, md_busy=0.

Pipeline advance, every rising edge when not in reset:
- E stage: if stall=0, load A3_E←A3_D and tnew_E←Tnew_D. If stall=1, load A3_E←0 and tnew_E←0 (bubble).
- M stage: A3_M←A3_E; tnew_M←(tnew_E==0 ? 0 : tnew_E−1).
- W stage: A3_W←A3_M. Remaining Tnew in W is always 0.

Register hazard check (combinational), for X in {E, M, W} with remaining r_E=tnew_E, r_M=tnew_M, r_W=0:
- match_rs_X = need_rs_D && rs_D!=0 && rs_D==A3_X. Same form for rt.
- Youngest matching stage wins, priority E > M > W.
- If no stage matches: fwd = 0.
- Otherwise: fwd selects the winning stage. That stage's r is compared against Tuse; stall_rs = (r > Tuse_rs_D). Same rule for rt.
- An older match is never used when a younger one exists, even if the older one is ready.
- Register 0 never matches and never stalls.

MD hazard:
- md_stall = md_use_D && md_cnt!=0.
- md_cnt update each edge:
  - if stall=0 and md_kind_D==01: load MULT_CYC;
  - else if stall=0 and md_kind_D==10: load DIV_CYC;
  - else if md_cnt!=0: decrement;
  - else hold at 0.
- A load takes priority over the decrement.
- md_kind_D is ignored while stall=1, because the instruction does not advance.

Stall combination:
- stall = stall_rs | stall_rt | md_stall.
- bubble_E = stall.
- fwd outputs remain valid during a stall; the datapath ignores them while stalling.

Latency:
- All outputs are combinational from registered state plus D inputs; there is no added cycle.
- A stalled instruction is re-evaluated each cycle and issues in the first cycle its check passes.

Reset mid-stall:
- Clears all state immediately.
- stall drops in the same cycle that reset_n falls.

Test Plan:
- lw $1 then add $2,$1,$3:
  - cycle 1: lw in E (tnew_E=2), add in D (Tuse_rs=1) → stall=1, fwd_rs=1.
  - next cycle: lw in M (tnew_M=1) → stall=0, fwd_rs=2.
- add $1 then beq $1,$0:
  - beq in D (Tuse=0) with add in E (tnew_E=1) → stall=1.
  - next cycle: add in M (tnew_M=0) → stall=0, fwd_rs=2.
- ori $4 then sw $4,0($5):
  - sw in D (Tuse_rt=2), ori in E (tnew_E=1) → stall=0, fwd_rt=1.
- Destination $0 and double-writer:
  - ori $0 then add $2,$0,$0 → stall=0, fwd_rs=fwd_rt=0.
  - add $1 (in M) and lw $1 (in E) → fwd_rs=1, stall follows the E stage (tnew_E=2).
- div then mflo:
  - div enters E → md_cnt=10, md_busy=1.
  - mflo held in D with stall=1 for exactly 10 cycles, then issues; md_busy=0 when it issues.
  - mult → 5 cycles.
  - add issued right after div (md_use_D=0) → stall=0.
- Async reset during md busy:
  - assert reset_n=0 with md_cnt=7 and a stall active → md_busy=0 and stall=0 before the next clock edge.
  - E/M/W A3 fields read 0 after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the D-stage hazard inputs (register usage, timing, destination and
//   mult/div class produced by the D-stage timing decoder) with the hazard
//   controller's decisions (stall, E-bubble, forwarding selects, md busy).
//
//   master : the pipeline side; drives the D-stage fields and reads the
//            decisions.
//   slave  : the hazard controller; reads the D-stage fields and drives the
//            decisions.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  // D-stage instruction description
  logic       need_rs_D;   // D instruction reads rs
  logic       need_rt_D;   // D instruction reads rt
  logic [2:0] Tuse_rs_D;   // cycles (from D) until rs is consumed
  logic [2:0] Tuse_rt_D;   // cycles (from D) until rt is consumed
  logic [2:0] Tnew_D;      // cycles after entering E until the result is ready
  logic [4:0] rs_D;        // rs index
  logic [4:0] rt_D;        // rt index
  logic [4:0] A3_D;        // destination register, 0 = no write
  logic [1:0] md_kind_D;   // 00 none, 01 mult-class, 10 div-class, 11 none
  logic       md_use_D;    // accesses HI/LO or the md unit

  // Hazard decisions
  logic       stall;       // hold PC and the IF/D register
  logic       bubble_E;    // D->E register loads a NOP
  logic [1:0] fwd_rs_D;    // rs source: 0 RF, 1 E, 2 M, 3 W
  logic [1:0] fwd_rt_D;    // rt source, same encoding
  logic       md_busy;     // md unit still counting

  modport master (
    output need_rs_D, need_rt_D, Tuse_rs_D, Tuse_rt_D, Tnew_D,
           rs_D, rt_D, A3_D, md_kind_D, md_use_D,
    input  stall, bubble_E, fwd_rs_D, fwd_rt_D, md_busy
  );

  modport slave (
    input  need_rs_D, need_rt_D, Tuse_rs_D, Tuse_rt_D, Tnew_D,
           rs_D, rt_D, A3_D, md_kind_D, md_use_D,
    output stall, bubble_E, fwd_rs_D, fwd_rt_D, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Stall / forwarding controller for the 5-stage MIPS pipeline.
//   Tracks the destination register and remaining Tnew of the instructions in
//   E, M and W, checks them against the D-stage instruction's sources and
//   Tuse, and models the mult/div busy window so HI/LO accesses wait.
//
//   Ports
//     clk      : core clock, rising edge
//     reset_n  : asynchronous active-low reset
//     hz       : hazard_ctrl_if.slave - D-stage fields in, decisions out
//
//   All outputs are combinational from registered state plus the D inputs.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYC = 5,   // busy cycles loaded when mult/multu/madd enters E
  parameter int DIV_CYC  = 10   // busy cycles loaded when div/divu enters E
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hz
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_kind_e;

  typedef struct packed {
    fwd_sel_e sel;
    logic     stall;
  } src_res_t;

  // ---------------------------------------------------------------------------
  // Pipeline tracking state
  // ---------------------------------------------------------------------------
  logic [4:0] a3_e_q,   a3_e_d;
  logic [2:0] tnew_e_q, tnew_e_d;
  logic [4:0] a3_m_q,   a3_m_d;
  logic [2:0] tnew_m_q, tnew_m_d;
  logic [4:0] a3_w_q,   a3_w_d;    // W result is always ready: no Tnew kept
  logic [3:0] md_cnt_q, md_cnt_d;

  logic     stall;
  logic     md_stall;
  src_res_t res_rs;
  src_res_t res_rt;

  // Resolve one source operand. The youngest stage holding the register wins
  // even if an older stage also writes it and is already ready: the older
  // value is stale by program order.
  function automatic src_res_t resolve_src(
    input logic       need,
    input logic [4:0] idx,
    input logic [2:0] tuse,
    input logic [4:0] a3_e,
    input logic [2:0] tnew_e,
    input logic [4:0] a3_m,
    input logic [2:0] tnew_m,
    input logic [4:0] a3_w
  );
    src_res_t res;
    res.sel   = FWD_RF;
    res.stall = 1'b0;
    // $0 is hard-wired: never forwarded, never a hazard.
    if (need && (idx != 5'd0)) begin
      if (idx == a3_e) begin
        res.sel   = FWD_E;
        res.stall = (tnew_e > tuse);
      end else if (idx == a3_m) begin
        res.sel   = FWD_M;
        res.stall = (tnew_m > tuse);
      end else if (idx == a3_w) begin
        res.sel   = FWD_W;
        res.stall = 1'b0;
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard decision (combinational)
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default on entry so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    res_rs   = resolve_src(hz.need_rs_D, hz.rs_D, hz.Tuse_rs_D,
                           a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    res_rt   = resolve_src(hz.need_rt_D, hz.rt_D, hz.Tuse_rt_D,
                           a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    md_stall = hz.md_use_D && (md_cnt_q != 4'd0);
    stall    = res_rs.stall | res_rt.stall | md_stall;
  end

  assign hz.stall    = stall;
  assign hz.bubble_E = stall;
  assign hz.fwd_rs_D = res_rs.sel;
  assign hz.fwd_rt_D = res_rt.sel;
  assign hz.md_busy  = (md_cnt_q != 4'd0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // A stalled D instruction does not advance; E receives a NOP instead.
    a3_e_d   = stall ? 5'd0 : hz.A3_D;
    tnew_e_d = stall ? 3'd0 : hz.Tnew_D;

    a3_m_d   = a3_e_q;
    tnew_m_d = (tnew_e_q == 3'd0) ? 3'd0 : tnew_e_q - 3'd1;

    a3_w_d   = a3_m_q;

    // A new md operation entering E reloads the counter even while the
    // previous window is still running; md_kind is meaningless when the
    // instruction is held in D.
    md_cnt_d = md_cnt_q;
    if (!stall && (md_kind_e'(hz.md_kind_D) == MD_MULT)) begin
      md_cnt_d = MULT_LD;
    end else if (!stall && (md_kind_e'(hz.md_kind_D) == MD_DIV)) begin
      md_cnt_d = DIV_LD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a3_e_q   <= 5'd0;
      tnew_e_q <= 3'd0;
      a3_m_q   <= 5'd0;
      tnew_m_q <= 3'd0;
      a3_w_q   <= 5'd0;
      md_cnt_q <= 4'd0;
    end else begin
      a3_e_q   <= a3_e_d;
      tnew_e_q <= tnew_e_d;
      a3_m_q   <= a3_m_d;
      tnew_m_q <= tnew_m_d;
      a3_w_q   <= a3_w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed instruction sequences against hazard_ctrl with hand-computed
//   expected stall / forwarding / md-busy values.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  hazard_ctrl_if hz_if ();

  hazard_ctrl #(
    .MULT_CYC (5),
    .DIV_CYC  (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present a D-stage instruction and let the combinational outputs settle.
  task automatic drive(input logic nrs, input logic nrt,
                       input logic [2:0] urs, input logic [2:0] urt,
                       input logic [2:0] tn,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] a3,
                       input logic [1:0] kind, input logic use_md);
    hz_if.need_rs_D = nrs;
    hz_if.need_rt_D = nrt;
    hz_if.Tuse_rs_D = urs;
    hz_if.Tuse_rt_D = urt;
    hz_if.Tnew_D    = tn;
    hz_if.rs_D      = rs;
    hz_if.rt_D      = rt;
    hz_if.A3_D      = a3;
    hz_if.md_kind_D = kind;
    hz_if.md_use_D  = use_md;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 2'd0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    repeat (3) begin
      nop();
      step();
    end
  endtask

  // Clock while the current D instruction is stalled; bounded so a stuck
  // stall shows up as a wrong count instead of a hang.
  task automatic count_stalls(output int n);
    n = 0;
    while ((hz_if.stall === 1'b1) && (n < 40)) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    nop();

    // ---------------- reset state
    #10;
    check("rst_stall",   32'(hz_if.stall),    0);
    check("rst_bubble",  32'(hz_if.bubble_E), 0);
    check("rst_fwd_rs",  32'(hz_if.fwd_rs_D), 0);
    check("rst_fwd_rt",  32'(hz_if.fwd_rt_D), 0);
    check("rst_md_busy", 32'(hz_if.md_busy),  0);
    reset_n = 1'b1;
    step();

    // ---------------- lw $1 ; add $2,$1,$3
    drive(0, 0, 3'd0, 3'd0, 3'd2, 5'd0, 5'd0, 5'd1, 2'd0, 0);
    check("lw_issue_stall", 32'(hz_if.stall), 0);
    step();
    drive(1, 1, 3'd1, 3'd1, 3'd1, 5'd1, 5'd3, 5'd2, 2'd0, 0);
    check("lwuse_e_stall",  32'(hz_if.stall),    1);
    check("lwuse_e_bubble", 32'(hz_if.bubble_E), 1);
    check("lwuse_e_fwdrs",  32'(hz_if.fwd_rs_D), 1);
    check("lwuse_e_fwdrt",  32'(hz_if.fwd_rt_D), 0);
    step();
    check("lwuse_m_stall",  32'(hz_if.stall),    0);
    check("lwuse_m_fwdrs",  32'(hz_if.fwd_rs_D), 2);
    step();
    flush();

    // ---------------- add $1 ; beq $1,$0
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd1, 2'd0, 0);
    step();
    drive(1, 1, 3'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 2'd0, 0);
    check("beq_e_stall", 32'(hz_if.stall),    1);
    check("beq_e_fwdrs", 32'(hz_if.fwd_rs_D), 1);
    check("beq_r0_fwdrt",32'(hz_if.fwd_rt_D), 0);
    step();
    check("beq_m_stall", 32'(hz_if.stall),    0);
    check("beq_m_fwdrs", 32'(hz_if.fwd_rs_D), 2);
    step();
    flush();

    // ---------------- ori $4 ; sw $4,0($5)
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd4, 2'd0, 0);
    step();
    drive(1, 1, 3'd1, 3'd2, 3'd0, 5'd5, 5'd4, 5'd0, 2'd0, 0);
    check("sw_stall", 32'(hz_if.stall),    0);
    check("sw_fwdrt", 32'(hz_if.fwd_rt_D), 1);
    check("sw_fwdrs", 32'(hz_if.fwd_rs_D), 0);
    step();
    flush();

    // ---------------- ori $0 ; add $2,$0,$0
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd0, 2'd0, 0);
    step();
    drive(1, 1, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd2, 2'd0, 0);
    check("r0_stall", 32'(hz_if.stall),    0);
    check("r0_fwdrs", 32'(hz_if.fwd_rs_D), 0);
    check("r0_fwdrt", 32'(hz_if.fwd_rt_D), 0);
    step();
    flush();

    // ---------------- add $1 (M) and lw $1 (E): younger writer wins
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd1, 2'd0, 0);
    step();
    drive(0, 0, 3'd0, 3'd0, 3'd2, 5'd0, 5'd0, 5'd1, 2'd0, 0);
    step();
    drive(1, 0, 3'd1, 3'd0, 3'd1, 5'd1, 5'd0, 5'd2, 2'd0, 0);
    check("dbl_fwdrs",   32'(hz_if.fwd_rs_D), 1);
    check("dbl_stall",   32'(hz_if.stall),    1);
    drive(1, 0, 3'd2, 3'd0, 3'd1, 5'd1, 5'd0, 5'd2, 2'd0, 0);
    check("dbl_u2_stall",32'(hz_if.stall),    0);
    drive(0, 0, 3'd1, 3'd0, 3'd1, 5'd1, 5'd0, 5'd2, 2'd0, 0);
    check("noneed_fwdrs",32'(hz_if.fwd_rs_D), 0);
    nop();
    step();
    // lw now in M (tnew 1), ready add in W: M must still win
    drive(1, 0, 3'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 2'd0, 0);
    check("dbl_m_fwdrs", 32'(hz_if.fwd_rs_D), 2);
    check("dbl_m_stall", 32'(hz_if.stall),    1);
    nop();
    step();
    drive(1, 0, 3'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 2'd0, 0);
    check("w_fwdrs",     32'(hz_if.fwd_rs_D), 3);
    check("w_stall",     32'(hz_if.stall),    0);
    flush();

    // ---------------- div ; mflo (10 cycles), add alongside div
    drive(0, 0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 2'b10, 1);
    check("div_issue_stall", 32'(hz_if.stall), 0);
    step();
    check("div_busy", 32'(hz_if.md_busy), 1);
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd2, 2'd0, 0);
    check("add_in_div_stall", 32'(hz_if.stall), 0);
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd8, 2'd0, 1);
    count_stalls(n);
    check("mflo_div_cycles", 32'(n), 10);
    check("mflo_div_busy",   32'(hz_if.md_busy), 0);
    step();

    // ---------------- mult ; mflo (5 cycles)
    drive(0, 0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1);
    check("mult_issue_stall", 32'(hz_if.stall), 0);
    step();
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd8, 2'd0, 1);
    count_stalls(n);
    check("mflo_mult_cycles", 32'(n), 5);
    step();

    // ---------------- div ; mult held: kind ignored while stalled
    drive(0, 0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 2'b10, 1);
    step();
    drive(0, 0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1);
    count_stalls(n);
    check("mult_held_cycles", 32'(n), 10);
    step();
    check("mult_after_div_busy", 32'(hz_if.md_busy), 1);
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd8, 2'd0, 1);
    count_stalls(n);
    check("mflo_after_mult", 32'(n), 5);
    step();

    // ---------------- reserved md_kind behaves as none
    drive(0, 0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 2'b11, 0);
    step();
    check("rsvd_busy", 32'(hz_if.md_busy), 0);
    flush();

    // ---------------- async reset while md busy and stalled
    drive(0, 0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 2'b10, 1);
    step();                                                    // cnt 10
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd9, 2'd0, 0);  // ori $9
    step();                                                    // cnt 9
    drive(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd10, 2'd0, 0); // add $10
    step();                                                    // cnt 8
    drive(1, 1, 3'd2, 3'd2, 3'd0, 5'd9, 5'd10, 5'd0, 2'd0, 1);
    check("pre_rst_stall8", 32'(hz_if.stall), 1);
    step();                                                    // cnt 7
    check("pre_rst_stall", 32'(hz_if.stall),    1);
    check("pre_rst_fwdrs", 32'(hz_if.fwd_rs_D), 3);
    check("pre_rst_fwdrt", 32'(hz_if.fwd_rt_D), 2);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_stall", 32'(hz_if.stall),    0);
    check("rst_mid_busy",  32'(hz_if.md_busy),  0);
    check("rst_mid_fwdrs", 32'(hz_if.fwd_rs_D), 0);
    #2 reset_n = 1'b1;
    #1;
    check("rel_fwdrs", 32'(hz_if.fwd_rs_D), 0);
    check("rel_fwdrt", 32'(hz_if.fwd_rt_D), 0);
    check("rel_stall", 32'(hz_if.stall),    0);
    step();
    check("rel_busy",  32'(hz_if.md_busy),  0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
